// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: load-use, mul/div RAW/WAW and mul/div structural stalls.
// Optional stall-cycle counter output when HAZARD_SCOREBOARD_STATS_EN is defined.
module hazard_scoreboard #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd,
  input  logic       id_reg_we,
  input  logic [1:0] id_kind,
  input  logic       ex_hold,
  input  logic       flush,
  input  logic       md_done,
  output logic       stall_id,
  output logic       id_issue,
  output logic       md_busy,
  output logic       md_kill,
  output logic       md_timeout
`ifdef HAZARD_SCOREBOARD_STATS_EN
  ,output logic [31:0] stall_cycles
`endif
);

  localparam logic [1:0] KIND_LOAD = 2'b01;
  localparam logic [1:0] KIND_MD   = 2'b10;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  md_state_t        r_md_state;
  logic             r_load_pend;
  logic [4:0]       r_load_rd;
  logic [4:0]       r_md_rd;
  logic [CNT_W-1:0] r_md_cnt;
  logic             r_md_kill;
  logic             r_md_timeout;

  logic             w_busy;
  logic             w_rs1_pend;
  logic             w_rs2_pend;
  logic             w_waw;
  logic             w_struct;
  logic             w_stall;
  logic             w_issue;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_busy = (r_md_state == MD_BUSY);

  // Only registered state feeds the pending check, so md_done frees the register one cycle later.
  assign w_rs1_pend = (id_rs1 != 5'd0) &&
                      ((r_load_pend && r_load_rd == id_rs1) || (w_busy && r_md_rd == id_rs1));
  assign w_rs2_pend = (id_rs2 != 5'd0) &&
                      ((r_load_pend && r_load_rd == id_rs2) || (w_busy && r_md_rd == id_rs2));
  assign w_waw      = id_reg_we && w_busy && (id_rd == r_md_rd) && (id_rd != 5'd0);
  assign w_struct   = (id_kind == KIND_MD) && w_busy;

  assign w_stall = reset_n && id_valid && !flush &&
                   ((id_rs1_used && w_rs1_pend) || (id_rs2_used && w_rs2_pend) || w_waw || w_struct);
  assign w_issue = reset_n && id_valid && !w_stall && !ex_hold && !flush;

  assign w_cnt_nxt = (&r_md_cnt) ? r_md_cnt : r_md_cnt + 1'b1;

  assign stall_id   = w_stall;
  assign id_issue   = w_issue;
  assign md_busy    = w_busy;
  assign md_kill    = r_md_kill;
  assign md_timeout = r_md_timeout;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_load_pend <= 1'b0;
      r_load_rd   <= 5'd0;
    end else if (flush) begin
      r_load_pend <= 1'b0;
    end else if (w_issue && id_kind == KIND_LOAD && id_reg_we && id_rd != 5'd0) begin
      r_load_pend <= 1'b1;
      r_load_rd   <= id_rd;
    end else if (!ex_hold) begin
      r_load_pend <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_md_state   <= MD_IDLE;
      r_md_rd      <= 5'd0;
      r_md_cnt     <= '0;
      r_md_kill    <= 1'b0;
      r_md_timeout <= 1'b0;
    end else begin
      r_md_kill <= 1'b0;
      case (r_md_state)
        MD_IDLE: begin
          if (w_issue && id_kind == KIND_MD) begin
            r_md_state <= MD_BUSY;
            // A mul/div without a real destination only occupies the unit.
            r_md_rd    <= id_reg_we ? id_rd : 5'd0;
            r_md_cnt   <= '0;
          end
        end
        MD_BUSY: begin
          if (md_done) begin
            r_md_state <= MD_IDLE;
          end else if (flush) begin
            r_md_state <= MD_IDLE;
            r_md_kill  <= 1'b1;
          end else begin
            r_md_cnt <= w_cnt_nxt;
            if (w_cnt_nxt >= CNT_W'(MD_TIMEOUT)) r_md_timeout <= 1'b1;
          end
        end
        default: r_md_state <= MD_IDLE;
      endcase
    end
  end

`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] r_stall_cycles;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     r_stall_cycles <= 32'd0;
    else if (w_stall) r_stall_cycles <= r_stall_cycles + 32'd1;
  end
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table plus multi-cycle hazard sequences.
module tb_hazard_scoreboard;
  logic       clock = 1'b0;
  logic       reset_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_reg_we;
  logic [1:0] id_kind;
  logic       ex_hold, flush, md_done;
  logic       stall_id, id_issue, md_busy, md_kill, md_timeout;
`ifdef HAZARD_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
`endif

  hazard_scoreboard #(.MD_TIMEOUT(64), .CNT_W(7)) dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_we(id_reg_we), .id_kind(id_kind),
    .ex_hold(ex_hold), .flush(flush), .md_done(md_done),
    .stall_id(stall_id), .id_issue(id_issue), .md_busy(md_busy),
    .md_kill(md_kill), .md_timeout(md_timeout)
`ifdef HAZARD_SCOREBOARD_STATS_EN
    ,.stall_cycles(stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  // Expected output vector order: {stall_id, id_issue, md_busy, md_kill, md_timeout}
  typedef struct {
    string      name;
    logic [4:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string      name;
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       we;
    logic [1:0] kind;
    logic       hold, fl;
    logic       e_stall, e_issue;
  } vec_t;
  vec_t vecs[$];

  int checks = 0;
  int failures = 0;

  always @(negedge clock) begin
    while (sb_q.size() > 0) begin
      automatic sb_t e = sb_q.pop_front();
      automatic logic [4:0] act = {stall_id, id_issue, md_busy, md_kill, md_timeout};
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got {stall,issue,busy,kill,tmo}=%b expected %b", e.name, act, e.exp);
      end
    end
  end

  task automatic ins(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic we, input logic [1:0] k);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rs1_used = u1; id_rs2_used = u2;
    id_rd = rd; id_reg_we = we; id_kind = k;
    ex_hold = 1'b0; flush = 1'b0; md_done = 1'b0;
  endtask

  task automatic nop();
    ins(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b00);
  endtask

  // Queue the expectation for the current inputs, then advance past the next edge.
  task automatic cyc(input string n, input logic [4:0] e);
    sb_t s;
    s.name = n; s.exp = e;
    sb_q.push_back(s);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back('{"alu_read",   1, 5,0, 1,0, 3,1, 2'b00, 0,0, 0,1});
    vecs.push_back('{"invalid",    0, 5,0, 1,0, 3,1, 2'b00, 0,0, 0,0});
    vecs.push_back('{"ex_hold",    1, 5,0, 1,0, 3,1, 2'b00, 1,0, 0,0});
    vecs.push_back('{"flush",      1, 5,0, 1,0, 3,1, 2'b00, 0,1, 0,0});
    vecs.push_back('{"kind_rsvd",  1, 1,2, 1,1, 3,1, 2'b11, 0,0, 0,1});
    vecs.push_back('{"md_hold",    1, 1,2, 1,1, 4,1, 2'b10, 1,0, 0,0});
    vecs.push_back('{"md_flush",   1, 1,2, 1,1, 4,1, 2'b10, 0,1, 0,0});
    vecs.push_back('{"load_hold",  1, 1,2, 1,1, 4,1, 2'b01, 1,0, 0,0});

    // Reset with a valid instruction present: everything must read 0.
    reset_n = 1'b0;
    ins(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 2'b10);
    cyc("reset", 5'b00000);
    reset_n = 1'b1;
    nop();
    cyc("post_reset_idle", 5'b00000);

    foreach (vecs[i]) begin
      ins(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
          vecs[i].rd, vecs[i].we, vecs[i].kind);
      ex_hold = vecs[i].hold; flush = vecs[i].fl;
      cyc(vecs[i].name, {vecs[i].e_stall, vecs[i].e_issue, 3'b000});
    end

    // Load-use: exactly one bubble.
    ins(1, 0, 0, 0, 0, 5, 1, 2'b01); cyc("lu_load_issue", 5'b01000);
    ins(1, 5, 0, 1, 0, 6, 1, 2'b00); cyc("lu_bubble", 5'b10000);
    cyc("lu_reader_issue", 5'b01000);

    // Load to x0 never blocks.
    ins(1, 0, 0, 0, 0, 0, 1, 2'b01); cyc("lx0_load", 5'b01000);
    ins(1, 0, 0, 1, 1, 6, 1, 2'b00); cyc("lx0_reader", 5'b01000);

    // ex_hold keeps the load pending.
    ins(1, 0, 0, 0, 0, 6, 1, 2'b01); cyc("lh_load", 5'b01000);
    ins(1, 0, 6, 0, 1, 7, 1, 2'b00); ex_hold = 1; cyc("lh_hold1", 5'b10000);
    cyc("lh_hold2", 5'b10000);
    ex_hold = 0; cyc("lh_release", 5'b10000);
    cyc("lh_issue", 5'b01000);

    // Mul/div RAW: done 10 cycles after issue, reader issues at 11.
    ins(1, 0, 0, 0, 0, 7, 1, 2'b10); cyc("raw_md_issue", 5'b01000);
    ins(1, 1, 7, 1, 1, 8, 1, 2'b00);
    for (int k = 1; k <= 10; k++) begin
      md_done = (k == 10);
      cyc($sformatf("raw_stall_%0d", k), 5'b10100);
    end
    md_done = 0; cyc("raw_issue_11", 5'b01000);

    // Structural conflict, then WAW.
    ins(1, 0, 0, 0, 0, 8, 1, 2'b10); cyc("st_md1", 5'b01000);
    ins(1, 0, 0, 0, 0, 9, 1, 2'b10);
    cyc("st_stall1", 5'b10100);
    cyc("st_stall2", 5'b10100);
    md_done = 1; cyc("st_done_same", 5'b10100);
    md_done = 0; cyc("st_md2_issue", 5'b01000);
    ins(1, 0, 0, 0, 0, 9, 1, 2'b00); cyc("waw_stall", 5'b10100);
    ins(1, 0, 0, 1, 1, 0, 1, 2'b00); cyc("waw_x0_ok", 5'b01100);
    ins(1, 4, 3, 1, 1, 2, 1, 2'b00); cyc("indep_ok", 5'b01100);

    // Flush while busy kills the mul/div for one cycle.
    ins(1, 0, 0, 0, 0, 3, 1, 2'b10); flush = 1; cyc("fl_cycle", 5'b00100);
    nop(); cyc("fl_kill", 5'b00010);
    cyc("fl_kill_gone", 5'b00000);

    // Flush with md_done: done wins, no kill.
    ins(1, 0, 0, 0, 0, 10, 1, 2'b10); cyc("fd_issue", 5'b01000);
    nop(); flush = 1; md_done = 1; cyc("fd_both", 5'b00100);
    ins(1, 10, 0, 1, 0, 2, 1, 2'b00); cyc("fd_no_kill", 5'b01000);

    // Mul/div without write-enable blocks only the unit.
    ins(1, 0, 0, 0, 0, 11, 0, 2'b10); cyc("nwe_issue", 5'b01000);
    ins(1, 11, 11, 1, 1, 11, 1, 2'b00); cyc("nwe_reader_ok", 5'b01100);
    ins(1, 0, 0, 0, 0, 12, 1, 2'b10); cyc("nwe_struct", 5'b10100);
    nop(); md_done = 1; cyc("nwe_done", 5'b00100);
    nop(); md_done = 1; cyc("done_in_idle", 5'b00000);

    // Timeout: md_done never arrives.
    ins(1, 0, 0, 0, 0, 12, 1, 2'b10); cyc("to_issue", 5'b01000);
    nop();
    for (int k = 1; k <= 64; k++) cyc($sformatf("to_busy_%0d", k), 5'b00100);
    for (int k = 65; k <= 68; k++) cyc($sformatf("to_flag_%0d", k), 5'b00101);
    md_done = 1; cyc("to_done", 5'b00101);
    md_done = 0; cyc("to_sticky", 5'b00001);

    // Reset mid-operation: busy mul/div dropped without a kill.
    ins(1, 0, 0, 0, 0, 13, 1, 2'b10); cyc("rs_issue", 5'b01001);
    ins(1, 13, 0, 1, 0, 5, 1, 2'b10);
    reset_n = 0; cyc("rs_reset", 5'b00000);
    reset_n = 1; nop(); cyc("rs_after", 5'b00000);

    @(negedge clock);
    if (sb_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Pipeline hazard controller that sits between the ID stage and the EX/MEM/WB stages, beside the forwarding unit.
- Tracks which destination registers are still pending from a load in flight and from the single iterative mul/div unit.
- Issues the ID stall and the mul/div kill.
- Covers the hazards that forwarding alone cannot resolve: load-use, mul/div RAW, mul/div WAW, and a structural conflict on the mul/div unit.

Parameters:
- MD_TIMEOUT, 64: maximum number of cycles a mul/div may stay busy before md_timeout is flagged.
- CNT_W, 7: width of the mul/div busy-cycle counter. Must satisfy 2^CNT_W > MD_TIMEOUT.

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1  in  5  rs1 index.
- id_rs2  in  5  rs2 index.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd  in  5  destination register index.
- id_reg_we  in  1  instruction writes rd.
- id_kind  in  2  00 ALU/other, 01 LOAD, 10 MULDIV, 11 reserved (treated as 00).
- ex_hold  in  1  downstream freeze; nothing issues.
- flush  in  1  squash of EX and younger instructions (branch/trap).
- md_done  in  1  mul/div result written this cycle.
- stall_id  out  1  hold IF/ID (combinational).
- id_issue  out  1  instruction advances ID->EX this cycle.
- md_busy  out  1  a mul/div is outstanding.
- md_kill  out  1  one-cycle abort pulse to the mul/div unit.
- md_timeout  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous, reset_n low):
  - All state cleared: load_pend=0, load_rd=0, md_state=MD_IDLE, md_rd=0, md_cnt=0.
  - Outputs: md_kill=0, md_timeout=0.
  - stall_id and id_issue evaluate to 0 during reset.
  - Asserting reset mid-operation drops any outstanding mul/div silently; no md_kill is issued.
- Pending check: pend(r) = r!=0 && ((load_pend && load_rd==r) || (md_state==MD_BUSY && md_rd==r)).
  - Uses registered state only. md_done clears the pending entry on the following cycle.
- Stall: stall_id = id_valid && !flush && (any of the following):
  - rs1_used && pend(rs1).
  - rs2_used && pend(rs2).
  - id_reg_we && md_state==MD_BUSY && id_rd==md_rd && id_rd!=0 (WAW).
  - id_kind==MULDIV && md_state==MD_BUSY (structural).
- Issue: id_issue = id_valid && !stall_id && !ex_hold && !flush.
- Load tracking:
  - On id_issue with LOAD, id_reg_we and id_rd!=0: load_pend<=1 and load_rd<=id_rd.
  - Otherwise, when !ex_hold: load_pend<=0. This gives exactly one load-use bubble.
  - While ex_hold is high, load_pend holds its value.
  - flush clears load_pend.
- Mul/div FSM:
  - MD_IDLE -> MD_BUSY on id_issue with MULDIV and id_reg_we. Latches md_rd=id_rd and sets md_cnt=0.
    - MULDIV with rd=0 or !id_reg_we still enters MD_BUSY for the structural hazard; it never blocks register reads.
  - MD_BUSY -> MD_IDLE on md_done.
  - MD_BUSY -> MD_IDLE on flush && !md_done, with md_kill=1 for exactly that cycle (registered, visible the next cycle).
  - If md_done and flush occur in the same cycle, done wins: no md_kill is issued and the result is committed.
  - md_done while in MD_IDLE is ignored.
- Busy counter:
  - In MD_BUSY, md_cnt increments each cycle and saturates at 2^CNT_W-1.
  - When md_cnt reaches MD_TIMEOUT, md_timeout<=1. It is sticky until reset.
- md_busy = (md_state==MD_BUSY).
- flush combined with id_valid: no issue and no stall.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_STATS_EN.
- When defined, the block adds output stall_cycles [31:0] (reset 0). It increments on every cycle with stall_id=1 and wraps at 2^32.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- LOAD x5 issues, next instruction is ADD reading x5 -> stall_id=1 for exactly 1 cycle, then id_issue=1.
- LOAD x0 followed by a reader of x0 -> no stall.
- MULDIV x7 issues, then a reader of x7 -> stall_id held until the cycle after md_done. md_done pulsed 10 cycles after issue -> the reader issues 11 cycles after the MULDIV.
- MULDIV busy, second MULDIV x9 (independent) in ID -> stall until md_done. With md_done and the new MULDIV in the same cycle -> the MULDIV still stalls that cycle and issues the next cycle.
- MULDIV busy, flush asserted -> md_kill pulse of 1 cycle, md_busy=0 the next cycle. Flush in the same cycle as md_done -> md_kill stays 0.
- With MD_TIMEOUT=64 and md_done never arriving -> md_timeout=1 after 64 busy cycles and stays 1 after a later md_done. reset_n low -> all outputs 0.
